// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester round-robin write arbiter feeding a register array
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   req0,
    input  logic [ADDR_W-1:0]      addr0,
    input  logic [DATA_W-1:0]      data0,
    input  logic                   req1,
    input  logic [ADDR_W-1:0]      addr1,
    input  logic [DATA_W-1:0]      data1,
    output logic                   gnt0,
    output logic                   gnt1,
    output logic                   regWrite,
    output logic [2**ADDR_W-1:0]   decOut,
    output logic [DATA_W-1:0]      writeData,
    output logic                   wbValid,
    output logic [ADDR_W-1:0]      wbAddr,
    output logic [15:0]            conflictCount
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                ptr;
    logic                any_gnt;
    logic                conflict;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_data;

    // Grants are gated by reset so nothing is accepted while the block is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset && !stall) begin
            gnt0 = req0 & (~req1 | ~ptr);
            gnt1 = req1 & (~req0 | ptr);
        end
    end

    assign any_gnt  = gnt0 | gnt1;
    assign conflict = req0 & req1 & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (gnt0) begin
            ptr <= 1'b1;
        end else if (gnt1) begin
            ptr <= 1'b0;
        end
    end

    // Capture registers only load on a grant, so they hold their last value in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_addr <= '0;
            cap_data <= '0;
        end else if (gnt0) begin
            cap_addr <= addr0;
            cap_data <= data0;
        end else if (gnt1) begin
            cap_addr <= addr1;
            cap_data <= data1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflictCount <= 16'h0000;
        end else if (conflict && conflictCount != 16'hFFFF) begin
            conflictCount <= conflictCount + 16'h0001;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Register 0 is hardwired to zero: its write is consumed but never strobed.
    always_comb begin
        state_next = any_gnt ? WRITE : IDLE;
        regWrite   = 1'b0;
        wbValid    = 1'b0;
        decOut     = '0;
        case (state)
            WRITE: begin
                if (cap_addr != '0) begin
                    regWrite         = 1'b1;
                    wbValid          = 1'b1;
                    decOut[cap_addr] = 1'b1;
                end
            end
            default: begin
                regWrite = 1'b0;
            end
        endcase
    end

    assign writeData = cap_data;
    assign wbAddr    = cap_addr;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench with a behavioural write-port model
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        req0, req1;
    logic [4:0]  addr0, addr1;
    logic [31:0] data0, data1;
    logic        gnt0, gnt1, regWrite, wbValid;
    logic [31:0] decOut, writeData;
    logic [4:0]  wbAddr;
    logic [15:0] conflictCount;

    int checks = 0;
    int failures = 0;

    // Model: favoured requester, in-flight write, last captured write, counter, register array.
    int          m_turn;
    bit          m_pv;
    logic [4:0]  m_la;
    logic [31:0] m_ld;
    int          m_conf;
    int          exp_win;
    logic [31:0] m_rf [32];
    logic [31:0] dut_rf [32];

    regfile_write_arbiter dut (
        .clk(clk), .reset(reset), .stall(stall),
        .req0(req0), .addr0(addr0), .data0(data0),
        .req1(req1), .addr1(addr1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .regWrite(regWrite), .decOut(decOut),
        .writeData(writeData), .wbValid(wbValid), .wbAddr(wbAddr),
        .conflictCount(conflictCount)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #2;
        if (regWrite) begin
            for (int k = 0; k < 32; k++) begin
                if (decOut[k]) dut_rf[k] = writeData;
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_turn = 0;
        m_pv   = 1'b0;
        m_la   = 5'd0;
        m_ld   = 32'd0;
        m_conf = 0;
    endtask

    task automatic model_predict();
        exp_win = -1;
        if (!reset && !stall) begin
            if (req0 && req1) exp_win = m_turn;
            else if (req0)    exp_win = 0;
            else if (req1)    exp_win = 1;
        end
    endtask

    task automatic model_commit();
        model_predict();
        if (reset) begin
            model_reset();
            return;
        end
        if (m_pv && m_la != 5'd0) m_rf[m_la] = m_ld;
        if (req0 && req1 && !stall && m_conf < 65535) m_conf++;
        m_pv = (exp_win >= 0);
        if (exp_win == 0) begin
            m_la = addr0;
            m_ld = data0;
        end else if (exp_win == 1) begin
            m_la = addr1;
            m_ld = data1;
        end
        if (exp_win >= 0) m_turn = 1 - exp_win;
    endtask

    task automatic drive(input bit r0, input logic [4:0] a0, input logic [31:0] d0,
                         input bit r1, input logic [4:0] a1, input logic [31:0] d1,
                         input bit st);
        @(negedge clk);
        req0 = r0; addr0 = a0; data0 = d0;
        req1 = r1; addr1 = a1; data1 = d1;
        stall = st;
        #1;
        model_predict();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; stall = 1'b0;
        model_reset();
        @(posedge clk);
        model_commit();
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0;
        req0 = 1'b1; addr0 = 5'd3; data0 = 32'h11;
        req1 = 1'b1; addr1 = 5'd4; data1 = 32'h22;
        model_reset();
        #1;
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            failures++; $display("FAIL reset_gnt: got %b want 00", {gnt0, gnt1});
        end
        checks++;
        if ({regWrite, wbValid, decOut, writeData, wbAddr, conflictCount} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: rw=%b wv=%b dec=%h wd=%h wa=%0d cc=%0d want all zero",
                     regWrite, wbValid, decOut, writeData, wbAddr, conflictCount);
        end
        apply_reset();
    endtask

    task automatic test_single_write();
        drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            failures++; $display("FAIL single_gnt: got %b want 10", {gnt0, gnt1});
        end
        tick();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
        checks++;
        if ({regWrite, wbValid, decOut, writeData, wbAddr} !== {1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 5'd5}) begin
            failures++;
            $display("FAIL single_write: rw=%b wv=%b dec=%h wd=%h wa=%0d want 1 1 00000020 deadbeef 5",
                     regWrite, wbValid, decOut, writeData, wbAddr);
        end
        tick();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
        checks++;
        if ({regWrite, wbValid, decOut, writeData, wbAddr} !== {1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 5'd5}) begin
            failures++;
            $display("FAIL idle_hold: rw=%b wv=%b dec=%h wd=%h wa=%0d want 0 0 0 deadbeef 5",
                     regWrite, wbValid, decOut, writeData, wbAddr);
        end
        tick();
    endtask

    task automatic test_contention();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'd3, 32'h0A0A0A0A, 1, 5'd7, 32'h1B1B1B1B, 0);
            checks++;
            if ({gnt0, gnt1} !== {1'(i % 2 == 0), 1'(i % 2 == 1)}) begin
                failures++; $display("FAIL contention_gnt[%0d]: got %b", i, {gnt0, gnt1});
            end
            checks++;
            if (conflictCount !== 16'(i)) begin
                failures++; $display("FAIL contention_count[%0d]: got %0d want %0d", i, conflictCount, i);
            end
            if (i > 0) begin
                checks++;
                if (decOut !== ((i % 2 == 1) ? 32'h8 : 32'h80)) begin
                    failures++; $display("FAIL contention_dec[%0d]: got %h", i, decOut);
                end
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 5'd3, 32'h0A0A0A0A, 0, 5'd7, 32'd0, 0);
            checks++;
            if (conflictCount !== 16'd4) begin
                failures++; $display("FAIL contention_single[%0d]: got %0d want 4", i, conflictCount);
            end
            tick();
        end
    endtask

    task automatic test_zero_reg();
        apply_reset();
        drive(1, 5'd2, 32'h55, 0, 5'd0, 32'd0, 0);
        tick();
        drive(0, 5'd0, 32'd0, 1, 5'd0, 32'h12345678, 0);
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            failures++; $display("FAIL zero_gnt: got %b want 01", {gnt0, gnt1});
        end
        tick();
        drive(1, 5'd6, 32'h66, 1, 5'd9, 32'h99, 0);
        checks++;
        if ({regWrite, wbValid, decOut, writeData} !== {1'b0, 1'b0, 32'h0, 32'h12345678}) begin
            failures++;
            $display("FAIL zero_write: rw=%b wv=%b dec=%h wd=%h want 0 0 0 12345678",
                     regWrite, wbValid, decOut, writeData);
        end
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            failures++; $display("FAIL zero_ptr: got %b want 10", {gnt0, gnt1});
        end
        tick();
        drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h99, 0);
        checks++;
        if ({regWrite, decOut} !== {1'b1, 32'h40}) begin
            failures++; $display("FAIL zero_next: rw=%b dec=%h want 1 00000040", regWrite, decOut);
        end
        tick();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
        tick();
    endtask

    task automatic test_stall();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd4, 32'h44, 1, 5'd8, 32'h88, 1);
            checks++;
            if ({gnt0, gnt1, conflictCount} !== {2'b00, 16'd0}) begin
                failures++;
                $display("FAIL stall_block[%0d]: gnt=%b cc=%0d want 00 0", i, {gnt0, gnt1}, conflictCount);
            end
            tick();
        end
        drive(1, 5'd4, 32'h44, 0, 5'd0, 32'd0, 0);
        checks++;
        if (gnt0 !== 1'b1) begin
            failures++; $display("FAIL stall_release: gnt0=%b want 1", gnt0);
        end
        tick();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
        checks++;
        if ({regWrite, decOut, writeData, conflictCount} !== {1'b1, 32'h10, 32'h44, 16'd0}) begin
            failures++;
            $display("FAIL stall_pending: rw=%b dec=%h wd=%h cc=%0d want 1 00000010 44 0",
                     regWrite, decOut, writeData, conflictCount);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(1, 5'd9, 32'hCAFE0009, 1, 5'd2, 32'h22, 0);
        tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({gnt0, gnt1, regWrite, wbValid, decOut, writeData, wbAddr, conflictCount} !== '0) begin
            failures++;
            $display("FAIL reset_mid: gnt=%b rw=%b dec=%h wd=%h wa=%0d cc=%0d want all zero",
                     {gnt0, gnt1}, regWrite, decOut, writeData, wbAddr, conflictCount);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({regWrite, decOut} !== '0) begin
            failures++; $display("FAIL reset_discard: rw=%b dec=%h want 0 0", regWrite, decOut);
        end
        tick();
        drive(1, 5'd4, 32'h44, 0, 5'd0, 32'd0, 0);
        checks++;
        if (gnt0 !== 1'b1) begin
            failures++; $display("FAIL reset_first_edge: gnt0=%b want 1", gnt0);
        end
        tick();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
        checks++;
        if ({regWrite, decOut, writeData} !== {1'b1, 32'h10, 32'h44}) begin
            failures++; $display("FAIL reset_after: rw=%b dec=%h wd=%h", regWrite, decOut, writeData);
        end
        checks++;
        if (dut_rf[9] !== m_rf[9]) begin
            failures++; $display("FAIL reset_reg9: got %h want %h", dut_rf[9], m_rf[9]);
        end
        tick();
    endtask

    task automatic test_random();
        bit          h0 = 0, h1 = 0, st;
        logic [4:0]  a0 = 0, a1 = 0;
        logic [31:0] d0 = 0, d1 = 0;
        logic [88:0] act, expv;
        bit          e_rw;
        logic [31:0] e_dec;
        for (int c = 0; c < 3000; c++) begin
            if (h0 && $urandom_range(0, 15) == 0) h0 = 0;
            else if (!h0 && $urandom_range(0, 1) == 1) begin
                h0 = 1; a0 = 5'($urandom_range(0, 7)); d0 = $urandom;
            end
            if (h1 && $urandom_range(0, 15) == 0) h1 = 0;
            else if (!h1 && $urandom_range(0, 1) == 1) begin
                h1 = 1; a1 = 5'($urandom_range(0, 7)); d1 = $urandom;
            end
            st = ($urandom_range(0, 4) == 0);
            drive(h0, a0, d0, h1, a1, d1, st);
            e_rw  = m_pv && (m_la != 5'd0);
            e_dec = e_rw ? (32'd1 << m_la) : 32'd0;
            expv  = {1'(exp_win == 0), 1'(exp_win == 1), e_rw, e_rw, e_dec, m_ld, m_la, 16'(m_conf)};
            act   = {gnt0, gnt1, regWrite, wbValid, decOut, writeData, wbAddr, conflictCount};
            checks++;
            if (act !== expv) begin
                failures++; $display("FAIL random[%0d]: got %h want %h", c, act, expv);
            end
            tick();
            if (exp_win == 0) h0 = 0;
            if (exp_win == 1) h1 = 0;
        end
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
        tick();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (dut_rf[k] !== m_rf[k]) begin
                failures++; $display("FAIL regfile[%0d]: got %h want %h", k, dut_rf[k], m_rf[k]);
            end
        end
        tick();
    endtask

    task automatic test_saturation();
        apply_reset();
        drive(1, 5'd1, 32'h1111, 1, 5'd2, 32'h2222, 0);
        for (int i = 1; i <= 70000; i++) begin
            tick();
            if (i == 65534 || i == 65535) begin
                #1;
                checks++;
                if (conflictCount !== 16'(m_conf)) begin
                    failures++; $display("FAIL sat_edge[%0d]: got %h want %h", i, conflictCount, 16'(m_conf));
                end
            end
        end
        #1;
        checks++;
        if (conflictCount !== 16'hFFFF) begin
            failures++; $display("FAIL saturation: got %h want ffff", conflictCount);
        end
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
        tick();
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            m_rf[k]   = 32'd0;
            dut_rf[k] = 32'd0;
        end
        test_reset();
        test_single_write();
        test_contention();
        test_zero_reg();
        test_stall();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the write data width, one bit per register flip-flop.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register index width; the register count is 2**ADDR_W (32).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  when 1, no new grant is issued.
REQ-006 req0 / req1  input  1 each  write request from requester 0 (ALU writeback) / requester 1 (load writeback).
REQ-007 addr0 / addr1  input  ADDR_W each  destination register index.
REQ-008 data0 / data1  input  DATA_W each  write data.
REQ-009 gnt0 / gnt1  output  1 each  combinational grant; the requester's data is accepted in that cycle.
REQ-010 regWrite  output  1  global write strobe to the register array.
REQ-011 decOut  output  2**ADDR_W  one-hot register select; bit k drives decOut1b of register k.
REQ-012 writeData  output  DATA_W  data broadcast to all registers.
REQ-013 wbValid / wbAddr  output  1 / ADDR_W  the write in flight this cycle, for hazard forwarding.
REQ-014 conflictCount  output  16  saturating count of arbitration losses.

Function
REQ-015 Grant rule:
- gnt0 = req0 & !stall & (!req1 | ptr==0).
- gnt1 = req1 & !stall & (!req0 | ptr==1).
- At most one grant SHALL be high in any cycle.
REQ-016 Round-robin pointer ptr: on any grant to requester i, ptr SHALL become the other requester on the next edge; with no grant, ptr SHALL hold.
REQ-017 Requester handshake:
- A requester SHALL hold req, addr and data stable until it sees its grant.
- Deasserting req before the grant withdraws the request without side effects.
REQ-018 Output stage state machine, states IDLE and WRITE:
- A grant in cycle N SHALL place the block in WRITE in cycle N+1, with the granted address and data registered.
- With no grant, the block SHALL return to (or stay in) IDLE.
- Back-to-back grants keep the block in WRITE on consecutive cycles; the sustained rate SHALL be one write per cycle.
REQ-019 In WRITE with captured address A != 0:
- regWrite=1.
- decOut has only bit A set.
- writeData = captured data.
- wbValid=1 and wbAddr=A.
REQ-020 In WRITE with A == 0 (hardwired zero register):
- The grant SHALL still be consumed.
- regWrite=0, decOut=0 and wbValid=0.
- writeData = captured data (don't-care to the array).
REQ-021 In IDLE: regWrite=0, decOut=0, wbValid=0, and writeData and wbAddr hold their last values.
REQ-022 Write latency SHALL be exactly one cycle from the grant edge to the regWrite cycle.
REQ-023 stall SHALL block only new grants; a write already captured SHALL complete in the following cycle regardless of stall.
REQ-024 conflictCount SHALL increment by 1 in each cycle where req0 & req1 & !stall, saturating at 16'hFFFF without wrap.
REQ-025 A cycle with stall=1 SHALL NOT count as a conflict.
REQ-026 When both requesters target the same address on consecutive grants, writes SHALL occur in grant order, so the later grant's data prevails.

Reset
REQ-027 While reset=1, independent of clk:
- state=IDLE, ptr=0 (requester 0 favoured).
- regWrite=0, decOut=0, writeData=0, wbValid=0, wbAddr=0, conflictCount=0.
REQ-028 gnt0 and gnt1 SHALL be 0 while reset=1.
REQ-029 A write captured but not yet performed when reset asserts SHALL be discarded; no regWrite SHALL be produced for it after reset deasserts.
REQ-030 The first rising edge after reset deasserts SHALL be a normal arbitration edge.

Verification
REQ-031 Single write: req0=1, addr0=5, data0=32'hDEADBEEF for one cycle -> gnt0=1 that cycle; next cycle regWrite=1, decOut=32'h00000020, writeData=32'hDEADBEEF, wbAddr=5.
REQ-032 Contention alternation: req0 and req1 held high with addr0=3 and addr1=7 from reset -> grants alternate 0,1,0,1; decOut alternates 32'h8 / 32'h80 on consecutive cycles; conflictCount increments only while both are still requesting.
REQ-033 Zero register: req1=1, addr1=0, data1=32'h12345678 -> gnt1=1; next cycle regWrite=0, decOut=0, wbValid=0; ptr advances to 0.
REQ-034 Stall: stall=1 with req0=1 for 3 cycles -> gnt0=0 throughout and conflictCount unchanged. Stall asserted in the cycle after a grant -> the pending write still appears with regWrite=1.
REQ-035 Reset mid-operation: grant to addr 9, then assert reset asynchronously before the next edge -> regWrite=0, decOut=0, conflictCount=0 immediately; no write to register 9 appears after reset releases.
REQ-036 Saturation: force both requesters high for 70000 cycles with stall=0 -> conflictCount=16'hFFFF and stays there.
